// File: rtl/safecrack_input_cond_if.sv
// Bundle of the board-side raw inputs and the conditioned outputs of the
// safecrack input conditioning stage.
//
// Signal summary:
//   btn_raw     [3:0] raw push buttons, active-low (1 = released)
//   ms_raw            raw password-change switch, active-high
//   btn         [3:0] conditioned press code, 4'b1111 when idle
//   btn_valid         one-cycle press strobe, coincident with a non-idle btn
//   ms                debounced password-change switch level
//   multi_err         one-cycle strobe when several buttons are accepted at once
//   tick              one-cycle strobe every TICK_CYCLES cycles
//   press_state       debug view of the press FSM state (0 = IDLE, 1 = HELD)
//
// Handshake semantics: btn_valid, multi_err and tick are strobes with no
// ready/back-pressure. Each is high for exactly one cycle and the consumer
// must take it in that cycle; btn carries its payload only while btn_valid
// is high.
//
// Modports: slave = the conditioning block, master = whoever drives the raw
// inputs and consumes the conditioned outputs.
interface safecrack_input_cond_if;
  logic [3:0] btn_raw;
  logic       ms_raw;
  logic [3:0] btn;
  logic       btn_valid;
  logic       ms;
  logic       multi_err;
  logic       tick;
  logic [0:0] press_state;

  modport master (
    output btn_raw, ms_raw,
    input  btn, btn_valid, ms, multi_err, tick, press_state
  );

  modport slave (
    input  btn_raw, ms_raw,
    output btn, btn_valid, ms, multi_err, tick, press_state
  );
endinterface

// File: rtl/safecrack_input_cond.sv
// Input conditioning stage in front of the safe-lock FSM.
//
// Takes four raw active-low push buttons and the active-high password-change
// switch, synchronises each bit through a two-flop chain, debounces each bit
// independently, and turns the stable button vector into exactly one
// single-cycle press code per physical press. Also produces the free-running
// 1 Hz tick for the lockout seconds counter.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    safecrack_input_cond_if.slave (raw inputs in, conditioned outputs out)
//
// Parameters:
//   DB_CYCLES   consecutive differing cycles needed to accept a new level (>= 1)
//   TICK_CYCLES tick period in clk cycles (>= 2)
module safecrack_input_cond #(
  parameter int DB_CYCLES   = 500000,
  parameter int TICK_CYCLES = 50000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  safecrack_input_cond_if.slave   bus
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int TW  = $clog2(TICK_CYCLES);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HELD = 1'b1;

  // Bit 4 is the ms switch (rests low), bits 3:0 are buttons (rest high).
  localparam logic [4:0] RST_LVL = 5'b01111;

  logic [4:0] sync1;
  logic [4:0] sync2;
  logic [4:0] stable;

  // ---------------------------------------------------------------------
  // Two-flop synchroniser, no logic between the stages.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= RST_LVL;
      sync2 <= RST_LVL;
    end else begin
      sync1 <= {bus.ms_raw, bus.btn_raw};
      sync2 <= sync1;
    end
  end

  // ---------------------------------------------------------------------
  // Per-bit debounce. The counter only advances while the synchronised value
  // disagrees with the accepted one; any agreeing cycle starts it over, so a
  // glitch shorter than DB_CYCLES cycles never reaches the stable level.
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < 5; i++) begin : g_db
    logic           st;
    logic [DBW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        st  <= RST_LVL[i];
      end else if (sync2[i] == st) begin
        cnt <= '0;
      end else if (cnt == DBW'(DB_CYCLES - 1)) begin
        st  <= sync2[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + DBW'(1);
      end
    end

    assign stable[i] = st;
  end

  assign bus.ms = stable[4];

  // ---------------------------------------------------------------------
  // Press FSM on the stable button vector.
  // ---------------------------------------------------------------------
  logic [3:0] sb;
  logic [2:0] n_zero;
  logic [0:0] state;
  logic [3:0] btn_q;
  logic       valid_q;
  logic       err_q;

  assign sb = stable[3:0];

  always_comb begin
    n_zero = '0;
    for (int i = 0; i < 4; i++) begin
      n_zero = n_zero + {2'b00, ~sb[i]};
    end
  end

  // Outputs default to idle every cycle, so each strobe lasts one cycle.
  // HELD swallows everything until all buttons are released, which is what
  // keeps a held press from repeating and makes releases silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      btn_q   <= 4'b1111;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      btn_q   <= 4'b1111;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (n_zero == 3'd1) begin
            btn_q   <= sb;
            valid_q <= 1'b1;
            state   <= HELD;
          end else if (n_zero > 3'd1) begin
            err_q   <= 1'b1;
            state   <= HELD;
          end
        end
        HELD: begin
          if (sb == 4'b1111) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.btn         = btn_q;
  assign bus.btn_valid   = valid_q;
  assign bus.multi_err   = err_q;
  assign bus.press_state = state;

  // ---------------------------------------------------------------------
  // Free-running tick counter, 0 .. TICK_CYCLES-1. The strobe is decoded
  // from the counter, so it is high in exactly the cycle the count is at
  // its terminal value.
  // ---------------------------------------------------------------------
  logic [TW-1:0] tcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (tcnt == TW'(TICK_CYCLES - 1)) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  assign bus.tick = (tcnt == TW'(TICK_CYCLES - 1));

endmodule

// File: tb/tb_safecrack_input_cond.sv
module tb_safecrack_input_cond;

  localparam int DB = 4;
  localparam int TK = 10;
  localparam int LAT = 2 + DB + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  safecrack_input_cond_if bus_if();

  safecrack_input_cond #(.DB_CYCLES(DB), .TICK_CYCLES(TK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  // ---------------- scoreboard state ----------------
  // entry = {is_multi_err, btn code, cycle at which it must appear}
  logic [36:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int unsigned rel_cyc = 0;
  bit tick_on = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic expect_ev(input logic kind, input logic [3:0] code, input int unsigned at);
    exp_q.push_back({kind, code, at});
  endtask

  // ---------------- driver tasks ----------------
  // Every drive happens 1 time unit after a rising edge; on return cyc holds
  // the number of edges seen, so the DUT first samples the change at cyc+1.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_btn(input logic [3:0] v);
    step(1);
    bus_if.btn_raw = v;
  endtask

  task automatic drive_ms(input logic v);
    step(1);
    bus_if.ms_raw = v;
  endtask

  task automatic release_reset();
    step(1);
    rst_n   = 1'b1;
    rel_cyc = cyc;
    tick_on = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [36:0] e;
    if (rst_n && tick_on)
      check("tick", bus_if.tick, ((cyc - rel_cyc) % TK) == TK - 1);

    if (bus_if.btn_valid || bus_if.multi_err) begin
      check("excl", bus_if.btn_valid & bus_if.multi_err, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_event", {bus_if.multi_err, bus_if.btn}, 0);
      end else begin
        e = exp_q.pop_front();
        check("event", {bus_if.multi_err, bus_if.btn, cyc}, e);
      end
    end else begin
      check("btn_idle", bus_if.btn, 4'b1111);
    end

    if (exp_q.size() != 0 && exp_q[0][31:0] < cyc) begin
      e = exp_q.pop_front();
      check("missed_event", 0, e);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int unsigned c;
    bus_if.btn_raw = 4'b1111;
    bus_if.ms_raw  = 1'b0;
    #2 rst_n = 1'b0;
    step(3);
    check("rst_btn", bus_if.btn, 4'b1111);
    check("rst_valid", bus_if.btn_valid, 0);
    check("rst_ms", bus_if.ms, 0);
    check("rst_err", bus_if.multi_err, 0);
    check("rst_tick", bus_if.tick, 0);
    check("rst_state", bus_if.press_state, 0);
    release_reset();

    // clean press
    drive_btn(4'b1110);
    expect_ev(1'b0, 4'b1110, cyc + LAT);
    step(20);
    check("held_state", bus_if.press_state, 1);
    drive_btn(4'b1111);
    step(10);
    check("released_state", bus_if.press_state, 0);

    // bounce 1101/1111 every 2 cycles for 12 cycles, then hold 1101
    for (int i = 0; i < 6; i++) begin
      drive_btn((i % 2) ? 4'b1111 : 4'b1101);
      step(1);
    end
    drive_btn(4'b1101);
    expect_ev(1'b0, 4'b1101, cyc + LAT);
    step(20);
    drive_btn(4'b1111);
    step(10);

    // simultaneous press, extra press while held, partial release
    drive_btn(4'b1001);
    expect_ev(1'b1, 4'b1111, cyc + LAT);
    step(12);
    drive_btn(4'b1000);
    step(12);
    drive_btn(4'b1011);
    step(12);
    check("partial_rel_state", bus_if.press_state, 1);
    drive_btn(4'b1111);
    step(10);
    drive_btn(4'b0111);
    expect_ev(1'b0, 4'b0111, cyc + LAT);
    step(12);
    drive_btn(4'b1111);
    step(10);

    // ms glitch of 3 cycles is rejected
    drive_ms(1'b1);
    step(2);
    drive_ms(1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("ms_glitch", bus_if.ms, 0);
    end
    // ms held: visible 2 + DB cycles after the edge
    drive_ms(1'b1);
    c = cyc;
    step(5);
    check("ms_before", {cyc - c, 31'd0, bus_if.ms}, {32'd5, 31'd0, 1'b0});
    step(1);
    check("ms_after", bus_if.ms, 1);
    step(4);
    drive_ms(1'b0);
    step(8);
    check("ms_low", bus_if.ms, 0);
    drive_ms(1'b1);
    step(8);
    check("ms_high_pre_rst", bus_if.ms, 1);

    // reset while HELD with the button still down
    drive_btn(4'b1110);
    expect_ev(1'b0, 4'b1110, cyc + LAT);
    step(10);
    check("pre_rst_state", bus_if.press_state, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_btn", bus_if.btn, 4'b1111);
    check("mid_rst_valid", bus_if.btn_valid, 0);
    check("mid_rst_err", bus_if.multi_err, 0);
    check("mid_rst_ms", bus_if.ms, 0);
    check("mid_rst_tick", bus_if.tick, 0);
    check("mid_rst_state", bus_if.press_state, 0);
    step(2);
    release_reset();
    expect_ev(1'b0, 4'b1110, cyc + LAT);
    step(20);
    check("ms_after_rst", bus_if.ms, 1);
    drive_btn(4'b1111);
    step(12);

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout: got running expected finished");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/safecrack_input_cond.md
Name: safecrack_input_cond

Overview:
- Input conditioning stage that sits directly upstream of the safe-lock FSM.
- Converts raw, bouncing, asynchronous board inputs into clean, clock-synchronous signals: four active-low push buttons plus the password-change switch.
- Downstream-facing button bus: idles at 4'b1111 and shows exactly one single-cycle press code per physical press.
- Also generates the 1 Hz tick used by the lockout seconds counter.

Parameters:
- DB_CYCLES, 500000: consecutive stable cycles required to accept a new input level. Legal range is 1 or more; 10 ms at 50 MHz.
- TICK_CYCLES, 50000000: tick period in clk cycles. Legal range is 2 or more; 1 s at 50 MHz.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_raw  in  4  raw push buttons, active-low (1 = released)
- ms_raw  in  1  raw password-change switch, active-high
- btn  out  4  conditioned press code. 4'b1111 when idle; for one cycle per press it equals the single-zero pattern of the pressed button
- btn_valid  out  1  one-cycle strobe, coincident with a non-idle btn
- ms  out  1  debounced ms level
- multi_err  out  1  one-cycle strobe when more than one button is accepted as pressed at the same time
- tick  out  1  one-cycle strobe, once every TICK_CYCLES cycles

Behaviour:
- Reset (asynchronous, active-low, takes effect immediately, including mid-operation):
  - btn=4'b1111, btn_valid=0, ms=0, multi_err=0, tick=0.
  - Synchronizers and stable registers: buttons reset to 1, ms resets to 0.
  - All counters reset to 0; press FSM goes to IDLE.
- Synchronizer: 2-flop chain per input bit (5 bits total). No logic between the flops.
- Debounce (independent per bit, 5 instances):
  - Counter width is $clog2(DB_CYCLES+1).
  - When the sync value equals the stable value, the counter clears.
  - Otherwise the counter increments. When it reaches DB_CYCLES-1, the stable value takes the sync value and the counter clears.
  - A glitch shorter than DB_CYCLES cycles never changes the stable value.
- ms = stable ms bit. Latency from raw edge: 2 + DB_CYCLES cycles.
- Press FSM, states IDLE and HELD, evaluated on the stable 4-bit button vector sb:
  - IDLE with sb == 1111: stay, all outputs idle.
  - IDLE with exactly one zero in sb: next cycle btn=sb and btn_valid=1, for exactly one cycle. Go to HELD.
  - IDLE with two or more zeros in sb (including bits stabilising in the same cycle): next cycle multi_err=1 for one cycle, btn stays 1111. Go to HELD.
  - HELD: btn=1111 and no strobes. Any additional press is ignored, with no event and no multi_err. Return to IDLE only when sb == 1111.
  - Raw-press to btn_valid latency: 2 + DB_CYCLES + 1 cycles.
  - A press is never repeated while held. A release never produces an event.
- btn, btn_valid and multi_err are registered outputs; btn_valid and multi_err are never high together.
- Tick:
  - Free-running counter from 0 to TICK_CYCLES-1, wrapping to 0.
  - tick=1 for exactly the cycle in which the counter equals TICK_CYCLES-1.
  - First tick comes TICK_CYCLES cycles after reset release. Unaffected by button activity.
- Back-to-back presses: press A, release (debounced), then press B produces two separate events. Minimum spacing is about 2*DB_CYCLES cycles.

Test Plan (DB_CYCLES=4, TICK_CYCLES=10):
- Clean press: btn_raw goes 1111 -> 1110 and is held for 20 cycles -> exactly one cycle with btn=1110 and btn_valid=1, 7 cycles after the edge; btn=1111 at all other times.
- Bounce: btn_raw toggles 1101/1111 every 2 cycles for 12 cycles, then holds 1101 -> one event btn=1101 only after the hold. The glitching alone produces no event and no multi_err.
- Simultaneous press: 1111 -> 1001 in a single cycle -> multi_err pulses once and btn_valid stays 0. A second button added while HELD, or releasing to 1011, produces nothing until all are released; then a fresh press of 0111 yields btn=0111.
- ms switch: ms_raw 0 -> 1 for 3 cycles then back to 0 -> ms stays 0. ms_raw held at 1 for 10 cycles -> ms=1 six cycles after the edge.
- Tick: run 35 cycles after reset release -> tick high at cycles 10, 20 and 30 only, each for a single cycle.
- Reset mid-press: drop rst_n low while HELD, with btn_raw still at 1110 -> outputs go to reset values immediately. After release, the held button is re-debounced and one new event btn=1110 appears.
